// File: rtl/lc3_control_fsm.sv
// LC-3 control sequencer: fetch/decode/execute state machine that drives the
// datapath load enables, bus gates, mux selects and active-low memory strobes.
// Every output is a decode of registered state only, so nothing combinational
// flows from an input to an output in the same cycle.
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2
  } state_t;

  // Counter preload: a memory state exits when the counter reads 0, so
  // loading MEM_WAIT-1 gives exactly MEM_WAIT cycles of residency.
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t     state, nxt;
  logic [3:0] wait_cnt;
  logic       led_done;  // set after the first PAUSE1 cycle
  logic       ir5_q;     // IR[5] captured at decode, keeps SR2MUX input-free

  function automatic logic is_mem(input state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

  // State register, memory wait counter and small side flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= HALTED;
      wait_cnt <= 4'd0;
      led_done <= 1'b0;
      ir5_q    <= 1'b0;
    end else begin
      state    <= nxt;
      if (is_mem(nxt) && (nxt != state))
        wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      led_done <= (state == PAUSE1);
      if (state == S32)
        ir5_q <= IR_5;
    end
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    unique case (state)
      HALTED: if (Run) nxt = S18;
      S18:    nxt = S33;
      S33:    if (wait_cnt == 4'd0) nxt = S35;
      S35:    nxt = S32;
      S32: begin
        unique case (Opcode)
          4'b0001: nxt = S01;
          4'b0101: nxt = S05;
          4'b1001: nxt = S09;
          4'b0000: nxt = S00;
          4'b1100: nxt = S12;
          4'b0100: nxt = S04;
          4'b0110: nxt = S06;
          4'b0111: nxt = S07;
          4'b1101: nxt = PAUSE1;
          default: nxt = S18;
        endcase
      end
      S01, S05, S09: nxt = S18;
      S00:    nxt = BEN ? S22 : S18;
      S22:    nxt = S18;
      S12:    nxt = S18;
      S04:    nxt = IR_11 ? S21 : S20;
      S21:    nxt = S18;
      S20:    nxt = S18;
      S06:    nxt = S25;
      S25:    if (wait_cnt == 4'd0) nxt = S27;
      S27:    nxt = S18;
      S07:    nxt = S23;
      S23:    nxt = S16;
      S16:    if (wait_cnt == 4'd0) nxt = S18;
      PAUSE1: if (Continue) nxt = PAUSE2;
      PAUSE2: if (!Continue) nxt = S18;
      default: nxt = HALTED;
    endcase
  end

  // Datapath control decode from the current state.
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'd0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'd0;
    ALUK       = 2'd0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    unique case (state)
      S18: begin  // MAR <- PC, PC <- PC+1
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S33, S25: begin  // memory read into MDR
        Mem_OE = 1'b0;
        LD_MDR = 1'b1;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05, S09: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR1MUX  = 1'b1;
        SR2MUX  = ir5_q;
        ALUK    = (state == S01) ? 2'd0 : (state == S05) ? 2'd1 : 2'd2;
      end
      S22: begin  // PC <- PC + off9
        ADDR2MUX = 2'd2;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
      end
      S12, S20: begin  // PC <- BaseR + 0
        ADDR1MUX = 1'b1;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
      end
      S04: begin  // R7 <- PC
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S21: begin  // PC <- PC + off11
        ADDR2MUX = 2'd3;
        PCMUX    = 2'd2;
        LD_PC    = 1'b1;
      end
      S06, S07: begin  // MAR <- BaseR + off6
        GateMARMUX = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'd1;
        LD_MAR     = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S23: begin  // MDR <- SR passed through the ALU
        ALUK    = 2'd3;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S16:    Mem_WE = 1'b0;
      PAUSE1: LD_LED = !led_done;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: two instances (MEM_WAIT 2 and 3), each driven by
// directed and random instruction streams; the expected per-cycle control word
// is built from the micro-operation list of each instruction.
module tb_lc3_control_fsm;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ov_t;

  typedef struct {
    ov_t o;
    bit  cont;
  } step_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] run = '0, cont = '0, ir5 = '0, ir11 = '0, ben = '0;
  logic [3:0] opc [2];

  int total = 0;
  int bad   = 0;
  step_t q[$];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we;
    ov_t        o;
    lc3_control_fsm #(.MEM_WAIT(g == 0 ? 2 : 3)) u_dut (
      .clk(clk), .reset_n(reset_n), .Run(run[g]), .Continue(cont[g]),
      .Opcode(opc[g]), .IR_5(ir5[g]), .IR_11(ir11[g]), .BEN(ben[g]),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
      .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
      .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
      .GateMARMUX(gate_marmux), .PCMUX(pcmux), .DRMUX(drmux),
      .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
      .ADDR2MUX(addr2mux), .ALUK(aluk), .Mem_OE(mem_oe), .Mem_WE(mem_we));
    assign o = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux,
                drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk, mem_oe, mem_we};
  end

  function automatic ov_t idle();
    ov_t o = '0;
    o.mem_oe = 1'b1;
    o.mem_we = 1'b1;
    return o;
  endfunction

  function automatic ov_t obs(input int w);
    return (w == 0) ? g_dut[0].o : g_dut[1].o;
  endfunction

  function automatic logic [3:0] cnt(input int w);
    return (w == 0) ? g_dut[0].u_dut.wait_cnt : g_dut[1].u_dut.wait_cnt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input ov_t o, input bit c = 1'b0);
    step_t s;
    s.o = o;
    s.cont = c;
    q.push_back(s);
  endtask

  // Micro-operations of one instruction, first S18 up to (not incl.) next S18.
  task automatic build(input int mw, input logic [3:0] op, input logic i5,
                       input logic i11, input logic b, input int p1, input int p2);
    ov_t o;
    q.delete();
    o = idle(); o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; push(o);
    for (int i = 0; i < mw; i++) begin
      o = idle(); o.mem_oe = 0; o.ld_mdr = 1; push(o);
    end
    o = idle(); o.gate_mdr = 1; o.ld_ir = 1; push(o);
    o = idle(); o.ld_ben = 1; push(o);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        o = idle(); o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.sr1mux = 1;
        o.sr2mux = i5;
        o.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
        push(o);
      end
      4'b0000: begin
        push(idle());
        if (b) begin
          o = idle(); o.addr2mux = 2; o.pcmux = 2; o.ld_pc = 1; push(o);
        end
      end
      4'b1100: begin
        o = idle(); o.addr1mux = 1; o.pcmux = 2; o.ld_pc = 1; push(o);
      end
      4'b0100: begin
        o = idle(); o.gate_pc = 1; o.drmux = 1; o.ld_reg = 1; push(o);
        o = idle(); o.pcmux = 2; o.ld_pc = 1;
        if (i11) o.addr2mux = 3; else o.addr1mux = 1;
        push(o);
      end
      4'b0110, 4'b0111: begin
        o = idle(); o.gate_marmux = 1; o.addr1mux = 1; o.addr2mux = 1;
        o.ld_mar = 1; push(o);
        if (op == 4'b0110) begin
          for (int i = 0; i < mw; i++) begin
            o = idle(); o.mem_oe = 0; o.ld_mdr = 1; push(o);
          end
          o = idle(); o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; push(o);
        end else begin
          o = idle(); o.aluk = 3; o.gate_alu = 1; o.ld_mdr = 1; push(o);
          for (int i = 0; i < mw; i++) begin
            o = idle(); o.mem_we = 0; push(o);
          end
        end
      end
      4'b1101: begin
        for (int i = 0; i < p1; i++) begin
          o = idle(); o.ld_led = (i == 0); push(o, i == p1 - 1);
        end
        for (int i = 0; i < p2; i++) push(idle(), i != p2 - 1);
      end
      default: ;
    endcase
  endtask

  // Walk n queued cycles on instance w (n<0: whole queue).
  task automatic walk(input int w, input string tag, input int n = -1);
    int lim = (n < 0) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      chk(tag, 32'(obs(w)), 32'(q[i].o));
      cont[w] = q[i].cont;
      @(posedge clk); #1;
    end
  endtask

  task automatic instr(input int w, input logic [3:0] op, input logic i5,
                       input logic i11, input logic b, input int p1 = 1, input int p2 = 1);
    opc[w] = op; ir5[w] = i5; ir11[w] = i11; ben[w] = b;
    build(w == 0 ? 2 : 3, op, i5, i11, b, p1, p2);
    walk(w, $sformatf("dut%0d_op%b", w, op));
  endtask

  task automatic start(input int w);
    chk($sformatf("halted%0d", w), 32'(obs(w)), 32'(idle()));
    run[w] = 1'b1;
    @(posedge clk); #1;
    run[w] = 1'($urandom_range(0, 1));  // Run left high must not matter
  endtask

  task automatic rnd_instr(input int w);
    logic [3:0] ops [11] = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100,
                            4'b0100, 4'b0110, 4'b0111, 4'b1101, 4'b0011, 4'b1111};
    instr(w, ops[$urandom_range(0, 10)], 1'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
  endtask

  initial begin
    opc[0] = '0;
    opc[1] = '0;
    // reset and idle
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("rst_out%0d", w), 32'(obs(w)), 32'(idle()));
      chk($sformatf("rst_cnt%0d", w), 32'(cnt(w)), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle0", 32'(obs(0)), 32'(idle()));
      chk("idle1", 32'(obs(1)), 32'(idle()));
    end

    // instance 0, MEM_WAIT=2: directed then random
    start(0);
    instr(0, 4'b0001, 1, 0, 0);
    instr(0, 4'b0000, 0, 0, 1);
    instr(0, 4'b0000, 0, 0, 0);
    instr(0, 4'b1100, 0, 0, 0);
    instr(0, 4'b0100, 0, 1, 0);
    instr(0, 4'b0100, 0, 0, 0);
    instr(0, 4'b0110, 0, 0, 0);
    instr(0, 4'b0111, 0, 0, 0);
    instr(0, 4'b1101, 0, 0, 0, 6, 3);
    instr(0, 4'b0101, 0, 0, 0);
    instr(0, 4'b1001, 1, 0, 0);
    instr(0, 4'b0011, 0, 0, 0);
    for (int i = 0; i < 30; i++) rnd_instr(0);

    // instance 1, MEM_WAIT=3
    start(1);
    instr(1, 4'b0111, 0, 0, 0);
    instr(1, 4'b0110, 1, 0, 0);
    instr(1, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 15; i++) rnd_instr(1);

    // STR interrupted by reset during its second write cycle
    opc[1] = 4'b0111;
    build(3, 4'b0111, 0, 0, 0, 1, 1);
    walk(1, "str_pre_rst", 9);
    chk("second_write", 32'(obs(1)), 32'(q[9].o));
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_out", 32'(obs(1)), 32'(idle()));
    chk("rst_mid_we", 32'(obs(1).mem_we), 32'd1);
    chk("rst_mid_cnt", 32'(cnt(1)), 32'd0);
    chk("rst_other", 32'(obs(0)), 32'(idle()));
    reset_n = 1'b1;
    run = '0;
    @(posedge clk); #1;
    chk("post_rst_halt", 32'(obs(1)), 32'(idle()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
